// File: rtl/mem_loader.sv
// mem_loader: write sequencer for the 8x16 register-file memory.
// Receives a byte stream over valid/ready and packs each byte pair
// little-endian into a 16-bit word. Each word is written to the next
// memory address, starting at 0. done is raised once DEPTH words are stored.
`timescale 1ns/1ps

module mem_loader #(
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [15:0]   din,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   words_written
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WR,
        DONE
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   words_q;
    logic [7:0]    lo_q;
    logic          byte_ready_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [15:0]   din_q;
    logic          busy_q;
    logic          done_q;

    logic [AW-1:0] ptr_d;
    logic [AW:0]   words_d;
    logic          xfer;

    // Next write pointer and word count; the pointer wraps modulo 2**AW.
    always_comb begin
        ptr_d   = ptr_q + AW'(1);
        words_d = words_q + (AW+1)'(1);
        xfer    = byte_valid && byte_ready_q;
    end

    // Control FSM with every output registered. The upper byte of din_q
    // serves as the high-byte latch, so no separate register is kept.
    // NOTE: state registers use non-blocking assignments so that every
    // branch reads the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            words_q      <= '0;
            lo_q         <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            din_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort) begin
            // A cancel overrides start and any byte transfer. The word count is kept.
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= LO;
                        ptr_q        <= '0;
                        words_q      <= '0;
                        done_q       <= 1'b0;
                        byte_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                LO: begin
                    if (xfer) begin
                        lo_q    <= byte_in;
                        state_q <= HI;
                    end
                end
                HI: begin
                    if (xfer) begin
                        din_q        <= {byte_in, lo_q};
                        waddr_q      <= ptr_q;
                        we_q         <= 1'b1;
                        byte_ready_q <= 1'b0;
                        state_q      <= WR;
                    end
                end
                WR: begin
                    we_q    <= 1'b0;
                    ptr_q   <= ptr_d;
                    words_q <= words_d;
                    if (words_d == DEPTH_C) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= LO;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    byte_ready_q <= 1'b0;
                    we_q         <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    // An abort during the write cycle suppresses the pulse, so the word
    // never reaches memory.
    assign we            = we_q & ~abort;
    assign byte_ready    = byte_ready_q;
    assign waddr         = waddr_q;
    assign din           = din_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = words_q;

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream write sequencer for the 8x16 register-file memory block.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs little-endian into 16-bit words.
- Writes each word to consecutive memory addresses through the memory's we/waddr/din write port, starting at address 0.
- Flags completion once DEPTH words are stored, so downstream read logic can start sweeping addr.

Parameters:
AW, 3, address width of target memory write port
DEPTH, 8, number of words loaded per run; legal range 1..2**AW

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load run from address 0
abort  input  1  synchronous cancel of current run; no further writes
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept byte_in this cycle
we  output  1  memory write enable, one-cycle pulse per word
waddr  output  AW  memory write address
din  output  16  memory write data, {high byte, low byte}
busy  output  1  run in progress (states LO, HI, WR)
done  output  1  all DEPTH words written; held until next start or reset
words_written  output  AW+1  count of words written in current/last run

Behaviour:
- Reset (async, active-high): state IDLE; byte_ready=0, we=0, waddr=0, din=0, busy=0, done=0, words_written=0; internal byte latches cleared.
- Byte transfer occurs only on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is a registered function of state: 1 in LO and HI, 0 elsewhere.
- State machine:
  - IDLE: wait. start=1 -> LO; clear ptr, words_written and done.
  - LO: on transfer, latch byte_in as low byte -> HI.
  - HI: on transfer, latch byte_in as high byte -> WR.
  - WR: for exactly one cycle, drive we=1, waddr=ptr, din={hi,lo}. Then ptr+=1 and words_written+=1. If the new count equals DEPTH -> DONE, else -> LO.
  - DONE: done=1, byte_ready=0. start=1 -> LO with counters cleared and done cleared in the same edge.
- Outside WR: we=0. waddr and din hold their last written values; they do not return to 0.
- Latency: we asserts in the cycle immediately after the edge that accepts the high byte. Minimum spacing between words is 3 cycles with byte_valid held high.
- busy=1 in LO, HI and WR; 0 in IDLE and DONE.
- ptr wraps modulo 2**AW. Because DEPTH<=2**AW, no address repeats within a run.
- start while busy=1 is ignored.
- abort (any state) -> IDLE on the next edge:
  - we forced 0 that cycle, even in WR, so no partial or pending write occurs.
  - words_written holds; done=0.
  - abort has priority over start and over a byte transfer on the same edge.
- byte_valid while byte_ready=0: byte is not consumed, and the source must hold it.
- reset mid-run: immediate return to reset values; no write is issued.

Test Plan:
- Reset, start, then stream 16 bytes 0x01,0x00,0x02,0x00,...,0x08,0x00 with byte_valid always high -> 8 we pulses at waddr 0..7 with din 0x0001..0x0008, each 3 cycles apart. done=1 after the 8th write; words_written=8.
- Throttled source: byte_valid toggles 1/0 each cycle, bytes 0xCD,0xAB -> exactly one write of din=0xABCD at waddr=0. No byte is duplicated or dropped.
- Abort the edge after the high byte is accepted in the 3rd word -> no we for word 3. State IDLE, words_written=2, done=0; memory readback of addr 0..1 matches, addr 2 unchanged.
- After done, pulse start and stream 0xEF,0xBE -> waddr restarts at 0 with din=0xBEEF, done clears, words_written=1 after the write.
- Assert reset while in HI with the low byte latched -> all outputs 0 immediately, no we pulse. A subsequent start begins at waddr=0.
- start pulsed while busy, and byte_valid high in IDLE/DONE -> no effect on ptr or counters, byte_ready stays 0, no transfer occurs.
